// File: rtl/exidle_mc.sv
// Idle/status word injector for the exbus transmit path: passes response words
// through with priority and fills quiet periods with status, interrupt and FIFO-error words.
module exidle_mc #(
    parameter int DW           = 35,
    parameter int NAUX         = 2,
    parameter int NINT         = 4,
    parameter bit OPT_IDLE     = 1'b1,
    parameter int SHORT_LGIDLE = 17,
    parameter int LGIDLE       = 25,
    parameter int NSHORT       = 8,
    parameter int LGHOLDOFF    = 20
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stb,
    input  logic [DW-1:0]   i_word,
    output logic            o_busy,
    input  logic [NAUX-1:0] i_aux,
    input  logic            i_cts,
    input  logic [NINT-1:0] i_int,
    input  logic            i_fifo_err,
    output logic            o_stb,
    output logic [DW-1:0]   o_word,
    input  logic            i_busy
);

    // kind_q   | meaning
    // K_NONE   | output idle, o_stb low
    // K_DATA   | passed-through data word held on output
    // K_STATUS | status/idle word held on output
    // K_FERR   | FIFO-error word held on output
    typedef enum logic [1:0] {
        K_NONE   = 2'd0,
        K_DATA   = 2'd1,
        K_STATUS = 2'd2,
        K_FERR   = 2'd3
    } kind_t;

    localparam logic [LGIDLE:0]    SHORT_RELOAD = (LGIDLE+1)'((64'd1 << SHORT_LGIDLE) - 64'd1);
    localparam logic [LGIDLE:0]    LONG_RELOAD  = (LGIDLE+1)'((64'd1 << LGIDLE) - 64'd1);
    localparam logic [LGHOLDOFF-1:0] HOLD_RELOAD = {LGHOLDOFF{1'b1}};
    localparam logic [3:0]         NSHORT_SAT   = 4'(NSHORT);
    localparam logic [3:0]         NSHORT_M1    = 4'(NSHORT - 1);

    function automatic logic [DW-1:0] mk_status(input logic [NAUX-1:0] aux,
                                                input logic [2:0]      code,
                                                input logic [NINT-1:0] ints);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 2]          = 2'b11;
        w[DW-3 -: NAUX]       = aux;
        w[DW-3-NAUX -: 3]     = code;
        w[DW-6-NAUX -: NINT]  = ints;
        return w;
    endfunction

    kind_t                kind_q;
    logic                 o_stb_q;
    logic [DW-1:0]        o_word_q;
    logic [NINT-1:0]      out_ints_q;
    logic                 out_cts_q;

    logic [NINT-1:0]      int_q, int_flag_q, int_flag_d;
    logic [NAUX-1:0]      aux_q;
    logic                 aux_flag_q, aux_flag_d;
    logic                 cts_flag_q, cts_flag_d;
    logic                 fifo_in_q, fifo_flag_q, fifo_flag_d;
    logic [LGHOLDOFF-1:0] hold_q, hold_d;
    logic [LGIDLE:0]      idle_cnt_q, idle_cnt_d;
    logic [3:0]           short_cnt_q, short_cnt_d, short_eff;

    logic                 r_busy, out_free, out_acc, acc_stat, acc_ferr, in_take;
    logic [NINT-1:0]      int_pend;
    logic                 cts_pend, aux_pend, ferr_pend, timeout;
    logic                 send_ferr, send_stat, stat_launch;
    logic [2:0]           stat_code;
    logic [DW-1:0]        in_word_fix;

    assign r_busy    = (kind_q == K_DATA);
    assign o_busy    = r_busy && i_busy;
    assign o_stb     = o_stb_q;
    assign o_word    = o_word_q;

    assign out_free  = !o_stb_q || !i_busy;
    assign out_acc   = o_stb_q && !i_busy;
    assign acc_stat  = out_acc && (kind_q == K_STATUS);
    assign acc_ferr  = out_acc && (kind_q == K_FERR);
    assign in_take   = i_stb && !o_busy;

    // Pending views drop whatever the word leaving this cycle carried, so it is not re-sent
    assign int_pend  = int_flag_q & ~(acc_stat ? out_ints_q : '0);
    assign cts_pend  = cts_flag_q && !(acc_stat && out_cts_q);
    assign aux_pend  = aux_flag_q && !acc_stat;
    assign ferr_pend = fifo_flag_q && !acc_ferr;
    assign timeout   = OPT_IDLE && (idle_cnt_q == '0);

    assign send_ferr   = ferr_pend && (hold_q == '0);
    assign send_stat   = (|int_pend) || cts_pend || aux_pend || timeout;
    assign stat_launch = !in_take && out_free && !send_ferr && send_stat;
    assign stat_code   = {1'b1, cts_pend, |int_pend};

    assign int_flag_d  = int_pend | (i_int & ~int_q);
    assign cts_flag_d  = cts_pend || !i_cts;
    assign aux_flag_d  = aux_pend || (i_aux != aux_q);
    assign fifo_flag_d = ferr_pend || (i_fifo_err && !fifo_in_q);

    always_comb begin
        in_word_fix = i_word;
        if (i_word[DW-1 -: 2] == 2'b11)
            in_word_fix[DW-3 -: NAUX] = i_aux;
    end

    always_comb begin
        short_eff = short_cnt_q;
        if (acc_stat && (short_cnt_q < NSHORT_SAT))
            short_eff = short_cnt_q + 4'd1;
        short_cnt_d = in_take ? 4'd0 : short_eff;

        idle_cnt_d = idle_cnt_q;
        if (in_take)
            idle_cnt_d = SHORT_RELOAD;
        else if (stat_launch)
            idle_cnt_d = (short_eff < NSHORT_M1) ? SHORT_RELOAD : LONG_RELOAD;
        else if (idle_cnt_q != '0)
            idle_cnt_d = idle_cnt_q - (LGIDLE+1)'(1);

        hold_d = hold_q;
        if (acc_ferr)
            hold_d = HOLD_RELOAD;
        else if (hold_q != '0)
            hold_d = hold_q - LGHOLDOFF'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            kind_q     <= K_NONE;
            o_stb_q    <= 1'b0;
            o_word_q   <= '0;
            out_ints_q <= '0;
            out_cts_q  <= 1'b0;
        end else if (in_take) begin
            kind_q     <= K_DATA;
            o_stb_q    <= 1'b1;
            o_word_q   <= in_word_fix;
            out_ints_q <= '0;
            out_cts_q  <= 1'b0;
        end else if (out_free) begin
            if (send_ferr) begin
                kind_q     <= K_FERR;
                o_stb_q    <= 1'b1;
                o_word_q   <= mk_status(i_aux, 3'b011, '0);
                out_ints_q <= '0;
                out_cts_q  <= 1'b0;
            end else if (send_stat) begin
                kind_q     <= K_STATUS;
                o_stb_q    <= 1'b1;
                o_word_q   <= mk_status(i_aux, stat_code, int_pend);
                out_ints_q <= int_pend;
                out_cts_q  <= cts_pend;
            end else begin
                kind_q     <= K_NONE;
                o_stb_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            int_q       <= '0;
            int_flag_q  <= '0;
            aux_q       <= '0;
            aux_flag_q  <= 1'b0;
            cts_flag_q  <= 1'b0;
            fifo_in_q   <= 1'b0;
            fifo_flag_q <= 1'b0;
            hold_q      <= '0;
            idle_cnt_q  <= SHORT_RELOAD;
            short_cnt_q <= 4'd0;
        end else begin
            int_q       <= i_int;
            int_flag_q  <= int_flag_d;
            aux_q       <= i_aux;
            aux_flag_q  <= aux_flag_d;
            cts_flag_q  <= cts_flag_d;
            fifo_in_q   <= i_fifo_err;
            fifo_flag_q <= fifo_flag_d;
            hold_q      <= hold_d;
            idle_cnt_q  <= idle_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end

endmodule

// File: tb/tb_exidle_mc.sv
// Bench for exidle_mc: directed scenarios plus random traffic, all compared
// cycle by cycle against a timestamp-based reference model.
module tb_exidle_mc;

    localparam int DW   = 35;
    localparam int NAUX = 2;
    localparam int NINT = 4;
    localparam int PS   = 16;   // short idle period
    localparam int PL   = 64;   // long idle period
    localparam int NSH  = 2;
    localparam int HOLD = 64;   // FIFO-error spacing
    localparam int KN = 0, KD = 1, KS = 2, KF = 3;

    logic            i_clk, i_reset, i_stb, i_cts, i_fifo_err, i_busy;
    logic [DW-1:0]   i_word;
    logic [NAUX-1:0] i_aux;
    logic [NINT-1:0] i_int;
    logic            o_busy, o_stb;
    logic [DW-1:0]   o_word;

    exidle_mc #(
        .DW(DW), .NAUX(NAUX), .NINT(NINT), .OPT_IDLE(1'b1),
        .SHORT_LGIDLE(4), .LGIDLE(6), .NSHORT(NSH), .LGHOLDOFF(6)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
        .o_busy(o_busy), .i_aux(i_aux), .i_cts(i_cts), .i_int(i_int),
        .i_fifo_err(i_fifo_err), .o_stb(o_stb), .o_word(o_word), .i_busy(i_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: output register plus pending events and due times
    int            cyc, m_due, m_last_ferr, m_nacc, m_kind;
    logic          m_stb, m_out_cts, m_cts, m_auxp, m_ferr;
    logic [DW-1:0] m_word;
    logic [3:0]    m_out_ints, m_ints, prev_ints;
    logic [1:0]    prev_aux;
    logic          prev_ferr;

    task automatic model_init();
        cyc = 0; m_due = PS; m_last_ferr = -1000; m_nacc = 0; m_kind = KN;
        m_stb = 1'b0; m_word = '0; m_out_ints = '0; m_out_cts = 1'b0;
        m_ints = '0; m_cts = 1'b0; m_auxp = 1'b0; m_ferr = 1'b0;
        prev_ints = '0; prev_aux = '0; prev_ferr = 1'b0;
    endtask

    task automatic model_step(input logic stb, input logic [DW-1:0] word, input logic [1:0] aux,
                              input logic cts, input logic [3:0] ints, input logic ferr,
                              input logic busy);
        int e;
        bit acc, take, free, tmo;
        logic [2:0] code;
        e    = cyc + 1;
        acc  = m_stb && !busy;
        take = stb && !(m_kind == KD && busy);
        free = !m_stb || !busy;
        if (acc && m_kind == KS) begin
            m_ints = m_ints & ~m_out_ints;
            if (m_out_cts) m_cts = 1'b0;
            m_auxp = 1'b0;
            if (m_nacc < NSH) m_nacc++;
        end
        if (acc && m_kind == KF) begin
            m_ferr = 1'b0;
            m_last_ferr = e;
        end
        tmo = (e >= m_due);
        if (take) begin
            m_stb = 1'b1; m_kind = KD; m_word = word;
            if (word[34:33] == 2'b11) m_word[32:31] = aux;
            m_due = e + PS; m_nacc = 0;
        end else if (free) begin
            if (m_ferr && (e - m_last_ferr >= HOLD)) begin
                m_stb = 1'b1; m_kind = KF;
                m_word = {2'b11, aux, 3'b011, 4'b0000, 24'd0};
            end else if (m_ints != 0 || m_cts || m_auxp || tmo) begin
                code = {1'b1, m_cts, |m_ints};
                m_stb = 1'b1; m_kind = KS;
                m_word = {2'b11, aux, code, m_ints, 24'd0};
                m_out_ints = m_ints; m_out_cts = m_cts;
                m_due = e + ((m_nacc + 1 < NSH) ? PS : PL);
            end else begin
                m_stb = 1'b0; m_kind = KN;
            end
        end
        m_ints = m_ints | (ints & ~prev_ints);
        if (!cts) m_cts = 1'b1;
        if (aux != prev_aux) m_auxp = 1'b1;
        if (ferr && !prev_ferr) m_ferr = 1'b1;
        prev_ints = ints; prev_aux = aux; prev_ferr = ferr;
        cyc = e;
    endtask

    // called right after a falling edge; returns at the next falling edge
    task automatic step(input logic stb, input logic [DW-1:0] word, input logic [1:0] aux,
                        input logic cts, input logic [3:0] ints, input logic ferr, input logic busy);
        check("o_stb", 64'(o_stb), 64'(m_stb));
        if (m_stb) check("o_word", 64'(o_word), 64'(m_word));
        i_stb = stb; i_word = word; i_aux = aux; i_cts = cts;
        i_int = ints; i_fifo_err = ferr; i_busy = busy;
        #1;
        check("o_busy", 64'(o_busy), 64'(m_kind == KD && busy));
        model_step(stb, word, aux, cts, ints, ferr, busy);
        @(negedge i_clk);
    endtask

    task automatic quiet(input int n, input logic [1:0] aux, input logic busy);
        for (int k = 0; k < n; k++) step(1'b0, '0, aux, 1'b1, 4'b0000, 1'b0, busy);
    endtask

    logic [63:0]   r64;
    logic [DW-1:0] rw;
    logic [3:0]    cur_ints;
    logic [1:0]    cur_aux;
    logic          cur_ferr;
    int            busy_pct;

    initial begin
        i_reset = 1'b1; i_stb = 1'b0; i_word = '0; i_aux = '0; i_cts = 1'b1;
        i_int = '0; i_fifo_err = 1'b0; i_busy = 1'b1;
        #2;
        check("rst_o_stb", 64'(o_stb), 64'd0);
        check("rst_o_busy", 64'(o_busy), 64'd0);
        repeat (2) @(negedge i_clk);
        check("rst_o_word", 64'(o_word), 64'd0);
        i_reset = 1'b0;
        model_init();

        // idle words only: 16, 16, then 64-cycle spacing
        quiet(120, 2'b00, 1'b0);

        // data word held through a 3-cycle stall, then idle restarts short
        step(1'b1, 35'h0_1234_5678, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1);
        quiet(3, 2'b00, 1'b1);
        quiet(20, 2'b00, 1'b0);

        // interrupt bit rising while the first status word is stalled
        step(1'b0, '0, 2'b00, 1'b1, 4'b0101, 1'b0, 1'b0);
        step(1'b0, '0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1);
        step(1'b0, '0, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1);
        quiet(2, 2'b00, 1'b1);
        quiet(4, 2'b00, 1'b0);

        // two FIFO-error pulses 10 cycles apart under holdoff
        step(1'b0, '0, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0);
        quiet(9, 2'b00, 1'b0);
        step(1'b0, '0, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0);
        quiet(80, 2'b00, 1'b0);

        // CTS drop with simultaneous data, then aux change; special input word
        step(1'b1, 35'h0_0BAD_F00D, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        quiet(3, 2'b00, 1'b0);
        quiet(4, 2'b10, 1'b0);
        step(1'b1, 35'h7_FFFF_0001, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0);
        quiet(4, 2'b01, 1'b0);

        // asynchronous reset while a data word is stalled
        step(1'b1, 35'h0_5555_AAAA, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b0, '0, 2'b01, 1'b1, 4'b1000, 1'b1, 1'b1);
        step(1'b0, '0, 2'b01, 1'b0, 4'b1000, 1'b0, 1'b1);
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_o_stb", 64'(o_stb), 64'd0);
        check("async_rst_o_busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        check("async_rst_o_word", 64'(o_word), 64'd0);
        i_reset = 1'b0;
        model_init();
        quiet(20, 2'b00, 1'b0);

        // random traffic
        cur_ints = '0; cur_aux = '0; cur_ferr = 1'b0; busy_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) busy_pct = $urandom_range(80);
            r64 = {$urandom(), $urandom()};
            rw  = r64[DW-1:0];
            if ($urandom_range(3) == 0) rw[34:33] = 2'b11;
            for (int k = 0; k < NINT; k++)
                if ($urandom_range(99) < 2) cur_ints[k] = ~cur_ints[k];
            if ($urandom_range(99) < 2) cur_aux = 2'($urandom());
            if ($urandom_range(99) < 2) cur_ferr = ~cur_ferr;
            step($urandom_range(99) < 10, rw, cur_aux, $urandom_range(99) >= 2,
                 cur_ints, cur_ferr, $urandom_range(99) < busy_pct);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
